// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one ALU between two valid/ready requesters (round-robin or fixed priority).
// Latency: accept at T, ALU driven T+1..T+ALU_LAT, rsp_valid at T+ALU_LAT+1; one op per ALU_LAT+2 cycles.
// Backpressure: one op in flight; requests wait in IDLE, the result is held in RESP until the owner takes it.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins contention,
// port 1 may starve); left undefined, contention alternates round-robin.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous abort of the in-flight op; blocks acceptance in IDLE
//   reqN_valid/ready     request handshake, payload reqN_ctl (5b), reqN_op_a/op_b (DW)
//   rspN_valid/ready     response handshake, payload rspN_data (DW)
//   alu_ctl/op_a/op_b    registered drive to the shared ALU; alu_result back from it
//   busy                 registered, high whenever the sequencer is not IDLE
module alu_share_arb #(
  parameter int DW      = 32,
  parameter int ALU_LAT = 1   // legal range 1..8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [4:0]    req0_ctl,
  input  logic [DW-1:0] req0_op_a,
  input  logic [DW-1:0] req0_op_b,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [4:0]    req1_ctl,
  input  logic [DW-1:0] req1_op_a,
  input  logic [DW-1:0] req1_op_b,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_data,
  output logic [4:0]    alu_ctl,
  output logic [DW-1:0] alu_op_a,
  output logic [DW-1:0] alu_op_b,
  input  logic [DW-1:0] alu_result,
  output logic          busy
);

  localparam int CW = 3;  // holds ALU_LAT-1 up to 7
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_owner;
  logic [4:0]    r_ctl;
  logic [DW-1:0] r_op_a;
  logic [DW-1:0] r_op_b;
  logic [DW-1:0] r_result;
  logic          r_rsp0_valid;
  logic          r_rsp1_valid;
  logic          r_busy;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic          r_last_grant;
`endif

  logic          w_grant;    // 0: port 0 wins, 1: port 1 wins
  logic          w_accept;
  logic          w_rsp_hs;
  logic [4:0]    w_ctl;
  logic [DW-1:0] w_op_a;
  logic [DW-1:0] w_op_b;

  // A lone valid requester always wins; only contention consults the policy.
  always_comb begin
    w_grant = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    w_grant = ~req0_valid & req1_valid;
`else
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req1_valid;
    end
`endif
  end

  assign req0_ready = (r_state == S_IDLE) & ~w_grant & req0_valid & ~flush;
  assign req1_ready = (r_state == S_IDLE) &  w_grant & req1_valid & ~flush;
  assign w_accept   = req0_ready | req1_ready;

  assign w_ctl  = w_grant ? req1_ctl  : req0_ctl;
  assign w_op_a = w_grant ? req1_op_a : req0_op_a;
  assign w_op_b = w_grant ? req1_op_b : req0_op_b;

  // Only the owner's valid is ever set, so either handshake term identifies completion.
  assign w_rsp_hs = (r_rsp0_valid & rsp0_ready) | (r_rsp1_valid & rsp1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_ctl        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_result     <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_last_grant <= 1'b1;  // port 0 wins the first contention
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ctl   <= w_ctl;
            r_op_a  <= w_op_a;
            r_op_b  <= w_op_b;
            r_owner <= w_grant;
            r_cnt   <= CNT_INIT;
            r_state <= S_EXEC;
            r_busy  <= 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            // Recorded at grant time so a later flush still counts as this port's turn.
            r_last_grant <= w_grant;
`endif
          end
        end
        S_EXEC: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_result     <= alu_result;
            r_rsp0_valid <= ~r_owner;
            r_rsp1_valid <= r_owner;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          // No accept on the completing cycle: IDLE is entered first.
          if (flush || w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign alu_ctl    = r_ctl;
  assign alu_op_a   = r_op_a;
  assign alu_op_b   = r_op_b;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_result;
  assign rsp1_data  = r_result;
  assign busy       = r_busy;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: instance 0 uses ALU_LAT=1, instance 1 uses ALU_LAT=4.
// Each instance has its own stimulus signals; a small ALU model answers on alu_result.
// Inputs change 2 time units after the rising edge, outputs are sampled 1 unit later.
module tb_alu_share_arb;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          flush      [2];
  logic          req0_valid [2];
  logic          req0_ready [2];
  logic [4:0]    req0_ctl   [2];
  logic [DW-1:0] req0_op_a  [2];
  logic [DW-1:0] req0_op_b  [2];
  logic          rsp0_valid [2];
  logic          rsp0_ready [2];
  logic [DW-1:0] rsp0_data  [2];
  logic          req1_valid [2];
  logic          req1_ready [2];
  logic [4:0]    req1_ctl   [2];
  logic [DW-1:0] req1_op_a  [2];
  logic [DW-1:0] req1_op_b  [2];
  logic          rsp1_valid [2];
  logic          rsp1_ready [2];
  logic [DW-1:0] rsp1_data  [2];
  logic [4:0]    alu_ctl    [2];
  logic [DW-1:0] alu_op_a   [2];
  logic [DW-1:0] alu_op_b   [2];
  logic [DW-1:0] alu_result [2];
  logic          busy       [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] alu_model(input logic [4:0] c, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    case (c)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result[0] = alu_model(alu_ctl[0], alu_op_a[0], alu_op_b[0]);
  assign alu_result[1] = alu_model(alu_ctl[1], alu_op_a[1], alu_op_b[1]);

  alu_share_arb #(.DW(DW), .ALU_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]), .req0_ctl(req0_ctl[0]),
    .req0_op_a(req0_op_a[0]), .req0_op_b(req0_op_b[0]),
    .rsp0_valid(rsp0_valid[0]), .rsp0_ready(rsp0_ready[0]), .rsp0_data(rsp0_data[0]),
    .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]), .req1_ctl(req1_ctl[0]),
    .req1_op_a(req1_op_a[0]), .req1_op_b(req1_op_b[0]),
    .rsp1_valid(rsp1_valid[0]), .rsp1_ready(rsp1_ready[0]), .rsp1_data(rsp1_data[0]),
    .alu_ctl(alu_ctl[0]), .alu_op_a(alu_op_a[0]), .alu_op_b(alu_op_b[0]),
    .alu_result(alu_result[0]), .busy(busy[0])
  );

  alu_share_arb #(.DW(DW), .ALU_LAT(4)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]), .req0_ctl(req0_ctl[1]),
    .req0_op_a(req0_op_a[1]), .req0_op_b(req0_op_b[1]),
    .rsp0_valid(rsp0_valid[1]), .rsp0_ready(rsp0_ready[1]), .rsp0_data(rsp0_data[1]),
    .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]), .req1_ctl(req1_ctl[1]),
    .req1_op_a(req1_op_a[1]), .req1_op_b(req1_op_b[1]),
    .rsp1_valid(rsp1_valid[1]), .rsp1_ready(rsp1_ready[1]), .rsp1_data(rsp1_data[1]),
    .alu_ctl(alu_ctl[1]), .alu_op_a(alu_op_a[1]), .alu_op_b(alu_op_b[1]),
    .alu_result(alu_result[1]), .busy(busy[1])
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs(input int d);
    flush[d]      = 1'b0;
    req0_valid[d] = 1'b0;
    req0_ctl[d]   = '0;
    req0_op_a[d]  = '0;
    req0_op_b[d]  = '0;
    rsp0_ready[d] = 1'b0;
    req1_valid[d] = 1'b0;
    req1_ctl[d]   = '0;
    req1_op_a[d]  = '0;
    req1_op_b[d]  = '0;
    rsp1_ready[d] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs(0);
    idle_inputs(1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs(0);
    idle_inputs(1);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy d%0d got %b exp 0", d, busy[d]); end
      checks++; if (rsp0_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid d%0d got %b exp 0", d, rsp0_valid[d]); end
      checks++; if (rsp1_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid d%0d got %b exp 0", d, rsp1_valid[d]); end
      checks++; if (req0_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_req0_ready d%0d got %b exp 0", d, req0_ready[d]); end
      checks++; if (alu_ctl[d] !== 5'd0) begin errors++; $display("FAIL reset_alu_ctl d%0d got %0h exp 0", d, alu_ctl[d]); end
      checks++; if (alu_op_a[d] !== '0) begin errors++; $display("FAIL reset_alu_op_a d%0d got %0h exp 0", d, alu_op_a[d]); end
      checks++; if (alu_op_b[d] !== '0) begin errors++; $display("FAIL reset_alu_op_b d%0d got %0h exp 0", d, alu_op_b[d]); end
      checks++; if (rsp0_data[d] !== '0) begin errors++; $display("FAIL reset_rsp0_data d%0d got %0h exp 0", d, rsp0_data[d]); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Port 0 alone, ALU_LAT=1: 5+7 returns 12 at T+2.
  task automatic test_single_port0();
    req0_valid[0] = 1'b1; req0_ctl[0] = 5'd0; req0_op_a[0] = 5; req0_op_b[0] = 7;
    rsp0_ready[0] = 1'b1;
    #1;
    checks++; if (req0_ready[0] !== 1'b1) begin errors++; $display("FAIL single_req0_ready got %b exp 1", req0_ready[0]); end
    checks++; if (req1_ready[0] !== 1'b0) begin errors++; $display("FAIL single_req1_ready got %b exp 0", req1_ready[0]); end
    tick();
    req0_valid[0] = 1'b0;
    #1;
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy_exec got %b exp 1", busy[0]); end
    checks++; if (alu_op_a[0] !== 32'd5 || alu_op_b[0] !== 32'd7) begin errors++; $display("FAIL single_alu_ops got %0d/%0d exp 5/7", alu_op_a[0], alu_op_b[0]); end
    checks++; if (rsp0_valid[0] !== 1'b0) begin errors++; $display("FAIL single_rsp0_early got %b exp 0", rsp0_valid[0]); end
    tick();
    #1;
    checks++; if (rsp0_valid[0] !== 1'b1) begin errors++; $display("FAIL single_rsp0_valid got %b exp 1", rsp0_valid[0]); end
    checks++; if (rsp0_data[0] !== 32'd12) begin errors++; $display("FAIL single_rsp0_data got %0d exp 12", rsp0_data[0]); end
    checks++; if (rsp1_valid[0] !== 1'b0) begin errors++; $display("FAIL single_rsp1_valid got %b exp 0", rsp1_valid[0]); end
    tick();
    #1;
    checks++; if (rsp0_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL single_done got valid %b busy %b exp 0 0", rsp0_valid[0], busy[0]); end
    rsp0_ready[0] = 1'b0;
  endtask

  // Both ports valid continuously: grants alternate, spaced ALU_LAT+2 = 3 cycles.
  task automatic test_back_to_back();
    int g [4];
    int t [4];
    int ng;
    int exp_g;
    do_reset();
    req0_valid[0] = 1'b1; req0_ctl[0] = 5'd0; req0_op_a[0] = 10;  req0_op_b[0] = 1;
    req1_valid[0] = 1'b1; req1_ctl[0] = 5'd1; req1_op_a[0] = 100; req1_op_b[0] = 3;
    rsp0_ready[0] = 1'b1; rsp1_ready[0] = 1'b1;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      #1;
      if (req0_ready[0] && req1_ready[0]) begin
        checks++; errors++; $display("FAIL b2b_double_grant at cycle %0d got both ready exp one", cyc);
      end
      if (req0_ready[0] || req1_ready[0]) begin
        g[ng] = req1_ready[0] ? 1 : 0;
        t[ng] = cyc;
        ng++;
      end
      if (rsp0_valid[0]) begin
        checks++; if (rsp0_data[0] !== 32'd11) begin errors++; $display("FAIL b2b_rsp0_data got %0d exp 11", rsp0_data[0]); end
      end
      if (rsp1_valid[0]) begin
        checks++; if (rsp1_data[0] !== 32'd97) begin errors++; $display("FAIL b2b_rsp1_data got %0d exp 97", rsp1_data[0]); end
      end
      tick();
    end
    req0_valid[0] = 1'b0;
    req1_valid[0] = 1'b0;
    checks++; if (ng != 4) begin errors++; $display("FAIL b2b_grant_count got %0d exp 4", ng); end
    for (int i = 0; i < ng; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 2;
`endif
      checks++; if (g[i] != exp_g) begin errors++; $display("FAIL b2b_grant%0d got port %0d exp port %0d", i, g[i], exp_g); end
      if (i > 0) begin
        checks++; if (t[i] - t[i-1] != 3) begin errors++; $display("FAIL b2b_spacing%0d got %0d exp 3", i, t[i] - t[i-1]); end
      end
    end
    for (int k = 0; k < 10 && busy[0]; k++) tick();
    #1;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_drain_busy got %b exp 0", busy[0]); end
    rsp0_ready[0] = 1'b0; rsp1_ready[0] = 1'b0;
    tick();
  endtask

  // ALU_LAT=4 with a response stalled for 3 cycles: ALU drive and response must hold.
  task automatic test_lat4_hold();
    req0_valid[1] = 1'b1; req0_ctl[1] = 5'd2; req0_op_a[1] = 32'hF0F0; req0_op_b[1] = 32'hFF00;
    rsp0_ready[1] = 1'b0;
    #1;
    checks++; if (req0_ready[1] !== 1'b1) begin errors++; $display("FAIL lat4_req0_ready got %b exp 1", req0_ready[1]); end
    tick();
    req0_valid[1] = 1'b0;
    req0_op_a[1]  = 32'h1234;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (alu_ctl[1] !== 5'd2 || alu_op_a[1] !== 32'hF0F0 || alu_op_b[1] !== 32'hFF00) begin
        errors++; $display("FAIL lat4_alu_stable c%0d got %0h/%0h/%0h exp 2/f0f0/ff00", k, alu_ctl[1], alu_op_a[1], alu_op_b[1]);
      end
      checks++; if (rsp0_valid[1] !== 1'b0 || busy[1] !== 1'b1) begin errors++; $display("FAIL lat4_exec c%0d got valid %b busy %b exp 0 1", k, rsp0_valid[1], busy[1]); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (rsp0_valid[1] !== 1'b1) begin errors++; $display("FAIL lat4_rsp_hold c%0d got valid %b exp 1", k, rsp0_valid[1]); end
      checks++; if (rsp0_data[1] !== 32'hF000) begin errors++; $display("FAIL lat4_rsp_data c%0d got %0h exp f000", k, rsp0_data[1]); end
      checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL lat4_busy c%0d got %b exp 1", k, busy[1]); end
      tick();
    end
    rsp0_ready[1] = 1'b1;
    #1;
    checks++; if (rsp0_valid[1] !== 1'b1) begin errors++; $display("FAIL lat4_rsp_at_hs got %b exp 1", rsp0_valid[1]); end
    tick();
    #1;
    checks++; if (rsp0_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin errors++; $display("FAIL lat4_after_hs got valid %b busy %b exp 0 0", rsp0_valid[1], busy[1]); end
    checks++; if (alu_op_a[1] !== 32'hF0F0) begin errors++; $display("FAIL lat4_idle_keeps_op got %0h exp f0f0", alu_op_a[1]); end
    rsp0_ready[1] = 1'b0;
    tick();
  endtask

  // Flush in the second EXEC cycle, then flush in IDLE, then a clean port-1 op (50-8=42).
  task automatic test_flush();
    req0_valid[1] = 1'b1; req0_ctl[1] = 5'd0; req0_op_a[1] = 1; req0_op_b[1] = 2;
    rsp0_ready[1] = 1'b1;
    #1;
    checks++; if (req0_ready[1] !== 1'b1) begin errors++; $display("FAIL flush_accept got %b exp 1", req0_ready[1]); end
    tick();
    req0_valid[1] = 1'b0;
    tick();
    flush[1] = 1'b1;
    #1;
    checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b exp 1", busy[1]); end
    tick();
    flush[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (rsp0_valid[1] !== 1'b0 || rsp1_valid[1] !== 1'b0) begin errors++; $display("FAIL flush_no_rsp c%0d got %b%b exp 00", k, rsp0_valid[1], rsp1_valid[1]); end
      checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL flush_idle c%0d got busy %b exp 0", k, busy[1]); end
      tick();
    end
    req1_valid[1] = 1'b1; req1_ctl[1] = 5'd1; req1_op_a[1] = 50; req1_op_b[1] = 8;
    rsp1_ready[1] = 1'b1;
    flush[1] = 1'b1;
    #1;
    checks++; if (req1_ready[1] !== 1'b0) begin errors++; $display("FAIL flush_idle_block got %b exp 0", req1_ready[1]); end
    tick();
    flush[1] = 1'b0;
    #1;
    checks++; if (req1_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin errors++; $display("FAIL flush_idle_release got ready %b busy %b exp 1 0", req1_ready[1], busy[1]); end
    tick();
    req1_valid[1] = 1'b0;
    #1;
    for (int k = 0; k < 10 && !rsp1_valid[1]; k++) begin
      tick();
      #1;
    end
    checks++; if (rsp1_valid[1] !== 1'b1) begin errors++; $display("FAIL flush_p1_rsp_valid got %b exp 1", rsp1_valid[1]); end
    checks++; if (rsp1_data[1] !== 32'd42) begin errors++; $display("FAIL flush_p1_rsp_data got %0d exp 42", rsp1_data[1]); end
    checks++; if (rsp0_valid[1] !== 1'b0) begin errors++; $display("FAIL flush_p1_rsp0 got %b exp 0", rsp0_valid[1]); end
    tick();
    #1;
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL flush_p1_done got busy %b exp 0", busy[1]); end
    rsp0_ready[1] = 1'b0; rsp1_ready[1] = 1'b0;
    tick();
  endtask

  // Reset while a response is pending, then contention: port 0 must win.
  task automatic test_reset_in_resp();
    req0_valid[0] = 1'b1; req0_ctl[0] = 5'd0; req0_op_a[0] = 3; req0_op_b[0] = 4;
    rsp0_ready[0] = 1'b0;
    tick();
    req0_valid[0] = 1'b0;
    tick();
    #1;
    checks++; if (rsp0_valid[0] !== 1'b1 || rsp0_data[0] !== 32'd7) begin errors++; $display("FAIL rstresp_pending got %b/%0d exp 1/7", rsp0_valid[0], rsp0_data[0]); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp0_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL rstresp_async got valid %b busy %b exp 0 0", rsp0_valid[0], busy[0]); end
    checks++; if (rsp0_data[0] !== '0 || alu_op_a[0] !== '0 || alu_ctl[0] !== 5'd0) begin errors++; $display("FAIL rstresp_regs got %0h/%0h/%0h exp 0/0/0", rsp0_data[0], alu_op_a[0], alu_ctl[0]); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    req0_valid[0] = 1'b1; req0_op_a[0] = 1; req0_op_b[0] = 1;
    req1_valid[0] = 1'b1; req1_op_a[0] = 9; req1_op_b[0] = 1;
    rsp0_ready[0] = 1'b1; rsp1_ready[0] = 1'b1;
    #1;
    checks++; if (req0_ready[0] !== 1'b1 || req1_ready[0] !== 1'b0) begin errors++; $display("FAIL rstresp_first_contention got %b%b exp 10", req0_ready[0], req1_ready[0]); end
    tick();
    req0_valid[0] = 1'b0;
    req1_valid[0] = 1'b0;
    for (int k = 0; k < 10 && busy[0]; k++) tick();
    #1;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstresp_drain got busy %b exp 0", busy[0]); end
    rsp0_ready[0] = 1'b0; rsp1_ready[0] = 1'b0;
    tick();
  endtask

  // Port 1 raises valid while busy and withdraws before IDLE: nothing happens on port 1.
  task automatic test_drop_while_busy();
    req0_valid[0] = 1'b1; req0_ctl[0] = 5'd3; req0_op_a[0] = 6; req0_op_b[0] = 3;
    rsp0_ready[0] = 1'b0;
    #1;
    checks++; if (req0_ready[0] !== 1'b1) begin errors++; $display("FAIL drop_p0_accept got %b exp 1", req0_ready[0]); end
    tick();
    req0_valid[0] = 1'b0;
    req1_valid[0] = 1'b1; req1_ctl[0] = 5'd0; req1_op_a[0] = 20; req1_op_b[0] = 22;
    rsp1_ready[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req1_ready[0] !== 1'b0) begin errors++; $display("FAIL drop_p1_ready_busy c%0d got %b exp 0", k, req1_ready[0]); end
      tick();
    end
    req1_valid[0] = 1'b0;
    rsp0_ready[0] = 1'b1;
    #1;
    checks++; if (rsp0_valid[0] !== 1'b1 || rsp0_data[0] !== 32'd5) begin errors++; $display("FAIL drop_p0_rsp got %b/%0d exp 1/5", rsp0_valid[0], rsp0_data[0]); end
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (busy[0] !== 1'b0 || rsp1_valid[0] !== 1'b0) begin errors++; $display("FAIL drop_p1_silent c%0d got busy %b rsp1 %b exp 0 0", k, busy[0], rsp1_valid[0]); end
      tick();
    end
    rsp0_ready[0] = 1'b0; rsp1_ready[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_port0();
    test_back_to_back();
    test_lat4_hold();
    test_flush();
    test_reset_in_resp();
    test_drop_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
